// File: rtl/vpu_ifetch_if.sv
// Instruction hand-off bus between fetch and execute: head-of-queue word, its
// address, and the valid/ready handshake.
interface vpu_ifetch_if #(
  parameter int unsigned ADDR_W = 6
);
  logic [31:0]       ir_out;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    output ir_out,
    output ir_pc,
    output ir_valid,
    input  ir_ready
  );

  modport slave (
    input  ir_out,
    input  ir_pc,
    input  ir_valid,
    output ir_ready
  );
endinterface

// File: rtl/vpu_ifetch.sv
// VPU instruction fetch: loadable program memory, PC with jump redirect, HALT
// detection and a 2-entry skid queue presenting instructions over valid/ready.
module vpu_ifetch #(
  parameter int unsigned ADDR_W  = 6,
  parameter logic [4:0]  HALT_OP = 5'b11111
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  vpu_ifetch_if.master      ir,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       fetch_count
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e            state_q;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_data_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] rd_pc_q;
  logic              pending_q;
  logic [31:0]       qdata_q [2];
  logic [ADDR_W-1:0] qpc_q [2];
  logic [1:0]        count_q;

  logic       in_run;
  logic       pop;
  logic       ret_halt;
  logic       flush;
  logic       push;
  logic       issue;
  logic [2:0] occ;

  assign in_run   = (state_q == StRun);
  assign pop      = ir.ir_valid & ir.ir_ready;
  assign ret_halt = pending_q & (rd_data_q[31:27] == HALT_OP);
  assign flush    = in_run & jump_valid;
  assign push     = pending_q & ~ret_halt & ~flush;
  // Slots committed next cycle: queued words plus the read in flight, less this pop.
  assign occ      = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
  assign issue    = in_run & ~flush & ~ret_halt & (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (prog_we && !in_run) begin
      mem[prog_addr] <= prog_data;
    end
    if (issue) begin
      rd_data_q <= mem[pc_q];
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      rd_pc_q     <= '0;
      pending_q   <= 1'b0;
      count_q     <= 2'd0;
      qdata_q[0]  <= '0;
      qdata_q[1]  <= '0;
      qpc_q[0]    <= '0;
      qpc_q[1]    <= '0;
      fetch_count <= '0;
    end else begin
      if (pop) begin
        fetch_count <= fetch_count + 32'd1;
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            pc_q    <= '0;
          end
        end
        StRun: begin
          if (flush) begin
            pc_q <= jump_addr;
          end else begin
            if (ret_halt) begin
              state_q <= StHalted;
            end
            if (issue) begin
              pc_q <= pc_q + ADDR_W'(1);
            end
          end
        end
        StHalted: begin
          if (start) begin
            state_q <= StRun;
            pc_q    <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase

      pending_q <= issue;
      if (issue) begin
        rd_pc_q <= pc_q;
      end

      if (flush || (start && state_q == StHalted)) begin
        count_q <= 2'd0;
      end else begin
        case ({push, pop})
          2'b11: begin
            if (count_q == 2'd1) begin
              qdata_q[0] <= rd_data_q;
              qpc_q[0]   <= rd_pc_q;
            end else begin
              qdata_q[0] <= qdata_q[1];
              qpc_q[0]   <= qpc_q[1];
              qdata_q[1] <= rd_data_q;
              qpc_q[1]   <= rd_pc_q;
            end
          end
          2'b01: begin
            qdata_q[0] <= qdata_q[1];
            qpc_q[0]   <= qpc_q[1];
            count_q    <= count_q - 2'd1;
          end
          2'b10: begin
            if (count_q == 2'd0) begin
              qdata_q[0] <= rd_data_q;
              qpc_q[0]   <= rd_pc_q;
            end else begin
              qdata_q[1] <= rd_data_q;
              qpc_q[1]   <= rd_pc_q;
            end
            count_q <= count_q + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign ir.ir_valid = (count_q != 2'd0);
  assign ir.ir_out   = qdata_q[0];
  assign ir.ir_pc    = qpc_q[0];
  assign busy        = in_run;
  assign halted      = (state_q == StHalted);

endmodule

// File: tb/tb_vpu_ifetch.sv
// Bench for vpu_ifetch: directed scenarios plus random programs, checked by a
// scoreboard filled from a program-walk model of the instruction memory.
module tb_vpu_ifetch;
  localparam int unsigned AW   = 6;
  localparam logic [31:0] HALT = 32'hF800_0000;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          jump_valid;
  logic [AW-1:0] jump_addr;
  logic          busy;
  logic          halted;
  logic [31:0]   fetch_count;

  vpu_ifetch_if #(.ADDR_W(AW)) ir ();

  vpu_ifetch #(.ADDR_W(AW), .HALT_OP(5'b11111)) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .jump_valid (jump_valid),
    .jump_addr  (jump_addr),
    .ir         (ir),
    .busy       (busy),
    .halted     (halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mem_m [64];
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned model_cnt = 0;
  int          edge_no = 0;
  logic          stall_p = 1'b0;
  logic          skip_p = 1'b0;
  logic [AW-1:0] pc_p = '0;
  logic [31:0]   ir_p = '0;

  always @(posedge clk) edge_no++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Expected stream from address a: consecutive words until a HALT word.
  function automatic int walk_to(input logic [AW-1:0] a);
    logic [AW-1:0] addr = a;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      if (mem_m[addr][31:27] == 5'b11111) return i;
      exp_q.push_back('{pc: addr, data: mem_m[addr]});
      addr = addr + AW'(1);
    end
    return 64;
  endfunction

  always @(negedge clk) begin
    if (sys_rst) begin
      exp_q.delete();
      model_cnt = 0;
      stall_p   = 1'b0;
    end else begin
      chk("fetch_count", 64'(fetch_count), 64'(model_cnt));
      if (stall_p && !skip_p) begin
        chk("hold_valid", 64'(ir.ir_valid), 64'd1);
        chk("hold_pc", 64'(ir.ir_pc), 64'(pc_p));
        chk("hold_ir", 64'(ir.ir_out), 64'(ir_p));
      end
      if (ir.ir_valid && ir.ir_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_xfer: got pc %0d ir %h, required no transfer",
                   ir.ir_pc, ir.ir_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("xfer_pc", 64'(ir.ir_pc), 64'(mon_e.pc));
          chk("xfer_ir", 64'(ir.ir_out), 64'(mon_e.data));
        end
        model_cnt++;
      end
      stall_p = ir.ir_valid && !ir.ir_ready;
      skip_p  = jump_valid || start;
      pc_p    = ir.ir_pc;
      ir_p    = ir.ir_out;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    cyc();
    prog_we   = 1'b0;
    mem_m[a]  = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while (!(exp_q.size() == 0 && halted && !ir.ir_valid) && c < 300) begin
      cyc();
      c++;
    end
    chk(name, 64'(c < 300), 64'd1);
  endtask

  int d;
  int r_edge;
  int njump;

  initial begin
    sys_rst    = 1'b1;
    start      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_data  = '0;
    jump_valid = 1'b0;
    jump_addr  = '0;
    ir.ir_ready = 1'b0;
    cyc();
    cyc();
    sys_rst = 1'b0;
    chk("rst_valid", 64'(ir.ir_valid), 64'd0);
    chk("rst_ir", 64'(ir.ir_out), 64'd0);
    chk("rst_pc", 64'(ir.ir_pc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_count", 64'(fetch_count), 64'd0);

    // Basic program with latency check
    load(0, 32'h0840_0005);
    load(1, 32'h1082_0003);
    load(2, 32'h18C4_1000);
    load(3, HALT);
    ir.ir_ready = 1'b1;
    do_start();
    d = walk_to(0);
    chk("busy_run", 64'(busy), 64'd1);
    chk("lat_t0", 64'(ir.ir_valid), 64'd0);
    cyc();
    chk("lat_t1", 64'(ir.ir_valid), 64'd0);
    cyc();
    chk("lat_t2_valid", 64'(ir.ir_valid), 64'd1);
    chk("lat_t2_pc", 64'(ir.ir_pc), 64'd0);
    wait_drain("drain_basic");
    chk("basic_halted", 64'(halted), 64'd1);
    chk("basic_busy", 64'(busy), 64'd0);
    chk("basic_count", 64'(fetch_count), 64'd3);

    // Backpressure from HALTED restart
    ir.ir_ready = 1'b0;
    do_start();
    d = walk_to(0);
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(ir.ir_valid), 64'd1);
      chk("stall_ir", 64'(ir.ir_out), 64'h0840_0005);
      chk("stall_pc", 64'(ir.ir_pc), 64'd0);
      cyc();
    end
    ir.ir_ready = 1'b1;
    wait_drain("drain_stall");
    chk("stall_count", 64'(fetch_count), 64'd6);

    // Redirect while pc 1 is accepted
    load(10, 32'h2A00_0001);
    load(11, HALT);
    ir.ir_ready = 1'b1;
    do_start();
    d = walk_to(0);
    cyc();
    cyc();
    cyc();
    chk("redir_pc1", 64'(ir.ir_pc), 64'd1);
    jump_valid = 1'b1;
    jump_addr  = 10;
    cyc();
    jump_valid = 1'b0;
    d = walk_to(10);
    chk("redir_j0", 64'(ir.ir_valid), 64'd0);
    cyc();
    chk("redir_j1", 64'(ir.ir_valid), 64'd0);
    cyc();
    chk("redir_j2_valid", 64'(ir.ir_valid), 64'd1);
    chk("redir_j2_pc", 64'(ir.ir_pc), 64'd10);
    wait_drain("drain_redir");
    chk("redir_count", 64'(fetch_count), 64'd9);

    // PC wrap 63 -> 0, HALT at address 0
    load(63, 32'h0800_0001);
    load(0, HALT);
    do_start();
    d = walk_to(0);
    jump_valid = 1'b1;
    jump_addr  = 63;
    cyc();
    jump_valid = 1'b0;
    d = walk_to(63);
    cyc();
    cyc();
    chk("wrap_pc63", 64'(ir.ir_pc), 64'd63);
    wait_drain("drain_wrap");
    chk("wrap_halted", 64'(halted), 64'd1);

    // Write ignored in RUN, then mid-stream reset
    load(0, 32'h0840_0005);
    load(5, 32'h3000_0005);
    load(6, HALT);
    do_start();
    d = walk_to(0);
    prog_we   = 1'b1;
    prog_addr = 5;
    prog_data = 32'hDEAD_BEEF;
    cyc();
    prog_we    = 1'b0;
    jump_valid = 1'b1;
    jump_addr  = 5;
    cyc();
    jump_valid = 1'b0;
    d = walk_to(5);
    wait_drain("drain_we");
    ir.ir_ready = 1'b0;
    do_start();
    d = walk_to(0);
    cyc();
    cyc();
    chk("pre_rst_valid", 64'(ir.ir_valid), 64'd1);
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    chk("mid_rst_valid", 64'(ir.ir_valid), 64'd0);
    chk("mid_rst_count", 64'(fetch_count), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_halted", 64'(halted), 64'd0);
    ir.ir_ready = 1'b1;
    do_start();
    d = walk_to(0);
    wait_drain("drain_refetch");
    chk("refetch_count", 64'(fetch_count), 64'd3);

    // Random programs, random backpressure, jumps and ignored writes
    for (int run = 0; run < 8; run++) begin
      for (int a = 0; a < 64; a++) load(AW'(a), $urandom);
      load(AW'($urandom_range(4, 63)), HALT);
      do_start();
      r_edge = edge_no;
      d = walk_to(0);
      njump = 0;
      for (int c = 0; c < 400 && !(exp_q.size() == 0 && halted && !ir.ir_valid); c++) begin
        ir.ir_ready = ($urandom_range(0, 3) != 0);
        if (edge_no + 1 - r_edge <= d && njump < 3 && $urandom_range(0, 9) == 0) begin
          jump_valid = 1'b1;
          jump_addr  = AW'($urandom);
        end else if (edge_no + 1 - r_edge <= d && $urandom_range(0, 9) == 0) begin
          prog_we   = 1'b1;
          prog_addr = AW'($urandom);
          prog_data = $urandom;
        end
        cyc();
        prog_we = 1'b0;
        if (jump_valid) begin
          jump_valid = 1'b0;
          r_edge = edge_no;
          d = walk_to(jump_addr);
          njump++;
        end
      end
      ir.ir_ready = 1'b1;
      wait_drain("drain_rand");
      chk("rand_busy", 64'(busy), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vpu_ifetch.md
Name: vpu_ifetch

Overview:
- Instruction fetch stage feeding the VPU execute stage's 32-bit instruction register.
- Holds a loadable instruction memory and a program counter.
- Presents instructions with a valid/ready handshake, buffered in a 2-entry skid queue.
- Supports jump redirect, HALT detection and a transferred-instruction counter.

Parameters:
ADDR_W, 6, instruction memory address width; DEPTH = 2**ADDR_W words of 32 bits
HALT_OP, 5'b11111, opcode in bits [31:27] that stops fetch

Ports:
clk  in  1  system clock, all state on rising edge
sys_rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: begin fetching at address 0 (IDLE or HALTED only)
prog_we  in  1  program memory write enable
prog_addr  in  ADDR_W  program write address
prog_data  in  32  program write data
jump_valid  in  1  redirect request
jump_addr  in  ADDR_W  redirect target
ir_out  out  32  instruction to execute stage
ir_pc  out  ADDR_W  address of ir_out
ir_valid  out  1  ir_out/ir_pc valid
ir_ready  in  1  execute stage accepts
busy  out  1  high in RUN
halted  out  1  high in HALTED
fetch_count  out  32  instructions transferred (valid&ready) since reset

Behaviour:
- Reset (sys_rst=1 at clk edge): state IDLE, pc=0, queue empty, no read pending, ir_valid=0, ir_out=0, ir_pc=0, busy=0, halted=0, fetch_count=0. Memory contents are not reset. Applies mid-operation; pending reads are discarded.
- Memory: synchronous write and synchronous read, 1-cycle read latency.
  - prog_we is honoured only in IDLE/HALTED; it is ignored in RUN.
- FSM:
  - IDLE: start -> RUN, pc=0.
  - RUN: fetch as below. A HALT_OP word returning from memory (and not flushed) -> HALTED.
  - HALTED: start -> RUN, pc=0, queue cleared.
  - jump_valid in IDLE/HALTED is ignored.
- Read issue in RUN: issue read at pc when (queue_count + pending - pop) < 2, where pop = ir_valid & ir_ready this cycle. On issue: pending=1, rd_pc=pc, pc=pc+1 mod DEPTH (wraps DEPTH-1 -> 0).
- Read return, the cycle after issue:
  - Non-HALT word: pushed into the queue together with rd_pc.
  - HALT word: not pushed; state -> HALTED; further issue stops. Instructions already queued still drain normally via handshake.
- Queue and output:
  - The queue head drives ir_out/ir_pc; ir_valid = queue non-empty.
  - Outputs are held stable while ir_valid & !ir_ready.
  - Push and pop in the same cycle are both honoured.
- Throughput and latency:
  - Throughput is 1 instruction/cycle with ir_ready held high.
  - start at edge t: read issued at t+1, ir_valid at t+2.
- jump_valid in RUN:
  - A pop in the same cycle completes; everything else is flushed: queue cleared, pending read discarded (including a HALT word).
  - pc=jump_addr.
  - First redirected instruction has ir_valid 2 cycles after the jump edge.
  - jump_valid wins over a same-cycle HALT return and over queue push.
- fetch_count increments on each valid&ready cycle and wraps at 2^32.
- busy = (state==RUN); halted = (state==HALTED).

Test Plan:
- Load words 0..3 with 32'h08400005, 32'h10820003, 32'h18C41000, HALT (32'hF8000000); start; ir_ready=1 -> ir_valid 2 cycles after start; ir_pc 0,1,2 on consecutive cycles; halted=1; fetch_count=3; busy=0.
- Same program, ir_ready=0 for 5 cycles after first valid -> ir_out stays 32'h08400005, ir_pc=0, no more than 2 queued; then ready=1 -> pc 0,1,2 delivered in order with no loss or duplication.
- Redirect: while pc 1 is presented and accepted, jump_valid=1 with jump_addr=10 (mem[10]=32'h2A000001) -> pc1 counted; next ir_pc is 10 two cycles later; words 2/3 are never presented.
- Wrap: ADDR_W=6, mem[63]=32'h08000001, mem[0]=HALT; jump to 63 -> ir_pc 63 presented, then halted=1 from the HALT word at address 0.
- Writes: prog_we to address 5 during RUN -> mem[5] unchanged. Reset asserted mid-stream with ir_valid=1 -> next cycle ir_valid=0, fetch_count=0, state IDLE; after start, the program is refetched from address 0 intact.
